// File: rtl/sad_i10_o3_core.sv
// ---------------------------------------------------------------------------
// sad_i10_o3_core
//
// Two-stage pipelined sum of absolute differences between two 5-element
// vectors of 1-bit unsigned values. For 1-bit elements |A[i]-B[i]| is just
// A[i] XOR B[i], so the result is the popcount of A XOR B (0..5).
//
// Ports
//   clk        rising-edge clock for all state
//   rst        asynchronous active-high reset, clears all pipeline state
//   in_valid   pi0..pi9 are sampled on this clock edge when high
//   pi0..pi4   vector A, element i = pi<i>
//   pi5..pi9   vector B, element i = pi<i+5>
//   out_valid  one-cycle pulse marking a new result on po0..po2
//   po0..po2   3-bit SAD result, po0 = LSB, po2 = MSB (registered)
//
// Latency is two clock edges; one result per cycle, no backpressure.
// ---------------------------------------------------------------------------
module sad_i10_o3_core (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic pi0,
  input  logic pi1,
  input  logic pi2,
  input  logic pi3,
  input  logic pi4,
  input  logic pi5,
  input  logic pi6,
  input  logic pi7,
  input  logic pi8,
  input  logic pi9,
  output logic out_valid,
  output logic po0,
  output logic po1,
  output logic po2
);

  logic [4:0] vec_a;
  logic [4:0] vec_b;
  logic [4:0] diff_q;
  logic       valid_q;
  logic [2:0] sad_q;
  logic [2:0] diff_sum;

  assign vec_a = {pi4, pi3, pi2, pi1, pi0};
  assign vec_b = {pi9, pi8, pi7, pi6, pi5};

  // Adds the five difference bits; the maximum is 5, so 3 bits never wrap
  // and codes 6/7 are unreachable.
  always_comb begin
    diff_sum = 3'd0;
    for (int i = 0; i < 5; i++) begin
      diff_sum = diff_sum + {2'b00, diff_q[i]};
    end
  end

  // Stage 1 captures the per-element differences only on accepted samples,
  // so input activity while in_valid is low leaves the pipeline untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q  <= 5'd0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        diff_q <= vec_a ^ vec_b;
      end
    end
  end

  // Stage 2 updates the result register only when stage 1 holds a valid
  // sample, which keeps po stable between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sad_q     <= 3'd0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= valid_q;
      if (valid_q) begin
        sad_q <= diff_sum;
      end
    end
  end

  assign po0 = sad_q[0];
  assign po1 = sad_q[1];
  assign po2 = sad_q[2];

endmodule

// File: tb/tb_sad_i10_o3_core.sv
// ---------------------------------------------------------------------------
// tb_sad_i10_o3_core
//
// Directed bench for sad_i10_o3_core. Inputs are driven and outputs checked
// on the falling clock edge; results appear two rising edges after a sample.
// ---------------------------------------------------------------------------
module tb_sad_i10_o3_core;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [4:0] a_drv;
  logic [4:0] b_drv;
  logic       out_valid;
  logic       po0;
  logic       po1;
  logic       po2;
  logic [2:0] po_bus;

  int n_checks;
  int n_fail;

  assign po_bus = {po2, po1, po0};

  sad_i10_o3_core dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .pi0       (a_drv[0]),
    .pi1       (a_drv[1]),
    .pi2       (a_drv[2]),
    .pi3       (a_drv[3]),
    .pi4       (a_drv[4]),
    .pi5       (b_drv[0]),
    .pi6       (b_drv[1]),
    .pi7       (b_drv[2]),
    .pi8       (b_drv[3]),
    .pi9       (b_drv[4]),
    .out_valid (out_valid),
    .po0       (po0),
    .po1       (po1),
    .po2       (po2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference SAD: sum of |a[i]-b[i]| computed with integer subtraction.
  function automatic logic [2:0] refSad(input logic [4:0] a, input logic [4:0] b);
    int s;
    int d;
    s = 0;
    for (int i = 0; i < 5; i++) begin
      d = int'(a[i]) - int'(b[i]);
      s = s + ((d < 0) ? -d : d);
    end
    return 3'(s);
  endfunction

  // Waits for the falling edge, then drives a new input set.
  task automatic applyStimulus(input logic [4:0] a, input logic [4:0] b, input logic v);
    @(negedge clk);
    a_drv    = a;
    b_drv    = b;
    in_valid = v;
  endtask

  task automatic checkOutput(input string tag, input logic exp_valid, input logic [2:0] exp_po);
    n_checks++;
    assert (out_valid === exp_valid)
    else begin
      n_fail++;
      $error("[TB] FAIL %s out_valid: observed %0b expected %0b", tag, out_valid, exp_valid);
    end
    n_checks++;
    assert (po_bus === exp_po)
    else begin
      n_fail++;
      $error("[TB] FAIL %s po: observed %0d expected %0d", tag, po_bus, exp_po);
    end
  endtask

  // One isolated sample: no pulse after one edge, result after two, then held.
  task automatic singleVector(input string tag, input logic [4:0] a, input logic [4:0] b,
                              input logic [2:0] prev_po, input logic [2:0] exp_po);
    applyStimulus(a, b, 1'b1);
    applyStimulus(~a, b, 1'b0);
    checkOutput({tag, "_lat1"}, 1'b0, prev_po);
    applyStimulus(a, ~b, 1'b0);
    checkOutput(tag, 1'b1, exp_po);
    applyStimulus(~a, ~b, 1'b0);
    checkOutput({tag, "_hold"}, 1'b0, exp_po);
  endtask

  logic [4:0] burst_a [5];
  logic [4:0] burst_b [5];
  logic [2:0] burst_e [5];
  logic [2:0] exp_po;
  logic [9:0] pat;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a_drv    = 5'd0;
    b_drv    = 5'd0;

    #1;
    checkOutput("reset_state", 1'b0, 3'd0);

    @(negedge clk);
    rst = 1'b0;

    singleVector("vec_01001_00101", 5'b01001, 5'b00101, 3'd0, 3'd2);
    singleVector("vec_01010_10011", 5'b01010, 5'b10011, 3'd2, 3'd3);
    singleVector("vec_00000_10111", 5'b00000, 5'b10111, 3'd3, 3'd4);
    singleVector("vec_11111_11011", 5'b11111, 5'b11011, 3'd4, 3'd1);
    singleVector("all_ones",        5'b11111, 5'b11111, 3'd1, 3'd0);
    singleVector("max_five",        5'b00000, 5'b11111, 3'd0, 3'd5);

    // Back-to-back burst of five distinct vectors.
    burst_a[0] = 5'b10101; burst_b[0] = 5'b01010; burst_e[0] = 3'd5;
    burst_a[1] = 5'b11000; burst_b[1] = 5'b10000; burst_e[1] = 3'd1;
    burst_a[2] = 5'b00111; burst_b[2] = 5'b00000; burst_e[2] = 3'd3;
    burst_a[3] = 5'b11110; burst_b[3] = 5'b11110; burst_e[3] = 3'd0;
    burst_a[4] = 5'b01100; burst_b[4] = 5'b10100; burst_e[4] = 3'd2;
    exp_po = 3'd5;
    for (int i = 0; i < 8; i++) begin
      if (i < 5) applyStimulus(burst_a[i], burst_b[i], 1'b1);
      else       applyStimulus(5'b11111, 5'b00000, 1'b0);
      if (i >= 2 && i < 7) begin
        exp_po = burst_e[i-2];
        checkOutput($sformatf("burst_%0d", i-2), 1'b1, exp_po);
      end else begin
        checkOutput($sformatf("burst_idle_%0d", i), 1'b0, exp_po);
      end
    end

    // Reset one cycle after a sample; the in-flight sample must vanish.
    applyStimulus(5'b00000, 5'b01111, 1'b1);
    applyStimulus(5'b00000, 5'b00000, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("reset_async", 1'b0, 3'd0);
    applyStimulus(5'b00000, 5'b00000, 1'b0);
    checkOutput("reset_held", 1'b0, 3'd0);
    @(negedge clk);
    rst      = 1'b0;
    a_drv    = 5'b11100;
    b_drv    = 5'b00000;
    in_valid = 1'b1;
    applyStimulus(5'b00000, 5'b00000, 1'b0);
    checkOutput("post_reset_no_pulse", 1'b0, 3'd0);
    applyStimulus(5'b00000, 5'b00000, 1'b0);
    checkOutput("post_reset_first", 1'b1, 3'd3);
    applyStimulus(5'b00000, 5'b00000, 1'b0);
    checkOutput("post_reset_idle", 1'b0, 3'd3);

    // Exhaustive sweep, back-to-back, checked at latency two.
    for (int i = 0; i < 1026; i++) begin
      pat = 10'(i);
      if (i < 1024) applyStimulus(pat[4:0], pat[9:5], 1'b1);
      else          applyStimulus(5'b00000, 5'b00000, 1'b0);
      if (i >= 2) begin
        pat    = 10'(i - 2);
        exp_po = refSad(pat[4:0], pat[9:5]);
        checkOutput($sformatf("sweep_%0d", i-2), 1'b1, exp_po);
        n_checks++;
        assert (po_bus < 3'd6)
        else begin
          n_fail++;
          $error("[TB] FAIL sweep_range_%0d po: observed %0d expected below 6", i-2, po_bus);
        end
      end
    end
    applyStimulus(5'b00000, 5'b00000, 1'b0);
    checkOutput("sweep_done", 1'b0, exp_po);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
